// File: rtl/i2s_rx_core.sv
// i2s_rx_core: oversampling I2S receiver that frames channel words and queues them in a small FIFO.
module i2s_rx_core #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  lsb_i,
    input  logic [1:0]            fmt_i,
    input  logic [1:0]            chm_i,
    input  logic [1:0]            chl_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_ch_o,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, HOLD} state_t;
    state_t state, state_n;
    logic [1:0] sck_q, ws_q, sd_q;
    logic sck_d, ws_prev, sck_rise, ws_edge, start, cap, done, keep;
    logic lj_l, lsb_l, ch_l, lj_n, lsb_n, ch_n;
    logic [1:0] chl_l, chm_l, chl_n, chm_n;
    logic [5:0] cnt, cnt_b, last;
    logic [6:0] nbits;
    logic [IW-1:0] idx;
    logic [DATA_WIDTH-1:0] w, w_n, push_w;
    logic push_q, push_ch, full, pop, wr;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    assign sck_rise = sck_q[1] & ~sck_d;
    assign ws_edge  = ws_q[1] ^ ws_prev;
    assign start    = sck_rise && ws_edge && state != IDLE;
    // Word format is taken from the inputs at the WS edge, else from the latched copy
    assign lj_n  = start ? fmt_i == 2'd1 : lj_l;
    assign lsb_n = start ? lsb_i : lsb_l;
    assign chl_n = start ? chl_i : chl_l;
    assign chm_n = start ? chm_i : chm_l;
    assign ch_n  = start ? ws_q[1] : ch_l;
    assign last  = {1'b0, chl_n, 3'b111};
    assign nbits = 7'({chl_n, 3'b000}) + 7'd8;
    assign cnt_b = start ? 6'd0 : cnt;
    // Bits land directly in left-aligned position so no final shift is needed
    assign idx   = lsb_n ? IW'(7'(DATA_WIDTH) - nbits + 7'(cnt_b)) : IW'(7'(DATA_WIDTH - 1) - 7'(cnt_b));
    assign cap   = sck_rise && (start ? lj_n : (state == SKIP || state == SHIFT));
    assign done  = cap && cnt_b == last;
    assign keep  = chm_n == 2'd1 ? !ch_n : chm_n == 2'd2 ? ch_n : 1'b1;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign rx_valid_o = count != '0;
    assign pop        = rx_valid_o && rx_ready_i;
    assign wr         = push_q && (!full || pop);
    assign rx_data_o  = rx_valid_o ? mem[rp][DATA_WIDTH-1:0] : '0;
    assign rx_ch_o    = rx_valid_o && mem[rp][DATA_WIDTH];
    assign busy_o     = state == SKIP || state == SHIFT;
    always_comb begin
        state_n = state == IDLE ? SYNC : !sck_rise ? state : start ? (lj_n ? SHIFT : SKIP) :
                  state == SKIP ? SHIFT : (state == SHIFT && done) ? HOLD : state;
        w_n = start ? '0 : w;
        if (cap) w_n[idx] = sd_q[1];
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            {sck_q, ws_q, sd_q, sck_d, ws_prev} <= '0;
            state <= IDLE;
            {lj_l, lsb_l, ch_l, chl_l, chm_l} <= '0;
            cnt <= '0;
            w <= '0;
            {push_q, push_ch, push_w} <= '0;
            {wp, rp, count, ovf_o} <= '0;
        end else begin
            sck_q <= {sck_q[0], i2s_sck_i};
            ws_q  <= {ws_q[0], i2s_ws_i};
            sd_q  <= {sd_q[0], i2s_sd_i};
            sck_d <= sck_q[1];
            if (sck_rise) ws_prev <= ws_q[1];
            if (!en_i) begin
                state <= IDLE;
                cnt <= '0;
                w <= '0;
                push_q <= 1'b0;
                {wp, rp, count, ovf_o} <= '0;
            end else begin
                state <= state_n;
                if (start) {lj_l, lsb_l, chl_l, chm_l, ch_l} <= {lj_n, lsb_n, chl_n, chm_n, ch_n};
                if (start || cap) cnt <= cap ? 6'(cnt_b + 6'd1) : 6'd0;
                w <= w_n;
                push_q <= done && keep;
                if (done) {push_ch, push_w} <= {ch_n, w_n};
                if (wr) wp <= AW'(wp + 1'b1);
                if (pop) rp <= AW'(rp + 1'b1);
                count <= count + (AW+1)'(wr) - (AW+1)'(pop);
                if (push_q && full && !pop) ovf_o <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem[wp] <= {push_ch, push_w};
    end
endmodule

// File: tb/tb_i2s_rx_core.sv
// tb_i2s_rx_core: directed I2S streams with hand-computed words, latency and flag checks.
module tb_i2s_rx_core;
    logic clk = 0, rst_n = 0, en = 0, lsb = 0, rdy = 0, sck = 0, ws = 0, sd = 0;
    logic [1:0] fmt = 0, chm = 0, chl = 0;
    logic busy, ovf, valid, ch;
    logic [31:0] data;
    int checks = 0, failures = 0;
    logic [32:0] got[$];

    always #5 clk = ~clk;

    i2s_rx_core #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .lsb_i(lsb), .fmt_i(fmt), .chm_i(chm), .chl_i(chl),
        .busy_o(busy), .ovf_o(ovf), .rx_valid_o(valid), .rx_ready_i(rdy), .rx_data_o(data),
        .rx_ch_o(ch), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd)
    );

    // Every accepted word is recorded as {ch, data}
    always @(negedge clk) if (valid && rdy) got.push_back({ch, data});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sbit(input logic w, input logic d, input bit lat, input string tag);
        ws = w; sd = d; sck = 0;
        repeat (3) tick();
        sck = 1;
        repeat (3) tick();
        if (lat) begin
            chk({tag, "_lat_e3"}, valid, 0);
            tick();
            chk({tag, "_lat_e4"}, valid, 1);
        end
    endtask

    // One channel slot; Philips data starts one bit after the WS edge, filler bits are 1
    task automatic slot(input logic w, input logic [31:0] v, input int n, input int nb,
                        input bit lj, input bit lb, input int lat, input string tag);
        for (int i = 0; i < nb; i++) begin
            int k;
            logic d;
            k = lj ? i : i - 1;
            d = (k >= 0 && k < n) ? v[lb ? k : n - 1 - k] : 1'b1;
            sbit(w, d, i == lat, tag);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [32:0] exp);
        logic [32:0] v;
        v = '1;
        if (got.size() > 0) v = got.pop_front();
        chk(tag, v, exp);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ch", ch, 0);
        rst_n = 1; en = 1; rdy = 1; fmt = 0; chl = 1; chm = 0; lsb = 0;
        tick();
        // Philips 16-bit stereo, preceded by a short right fragment
        for (int i = 0; i < 4; i++) sbit(1, 1, 0, "pre");
        slot(0, 32'hA5C3, 16, 32, 0, 0, 16, "t1_l");
        slot(1, 32'h1234, 16, 32, 0, 0, 16, "t1_r");
        pop_chk("t1_word_l", {1'b0, 32'hA5C30000});
        pop_chk("t1_word_r", {1'b1, 32'h12340000});
        chk("t1_qsize", got.size(), 0);
        // Left-justified 24-bit LSB first
        fmt = 1; chl = 2; lsb = 1;
        slot(0, 32'h123456, 24, 32, 1, 1, 23, "t2");
        pop_chk("t2_word", {1'b0, 32'h12345600});
        chk("t2_qsize", got.size(), 0);
        // Right-only channel mask
        fmt = 0; chl = 0; lsb = 0; chm = 2;
        for (int i = 0; i < 4; i++) sbit(1, 0, 0, "pre3");
        for (int r = 0; r < 3; r++) begin
            slot(0, 32'h11, 8, 16, 0, 0, -1, "t3_l");
            slot(1, 32'h22, 8, 16, 0, 0, -1, "t3_r");
        end
        for (int r = 0; r < 3; r++) pop_chk("t3_word", {1'b1, 32'h22000000});
        chk("t3_qsize", got.size(), 0);
        // Overflow with consumer stalled
        chm = 0; rdy = 0;
        slot(0, 32'h01, 8, 16, 0, 0, -1, "t4");
        slot(1, 32'h02, 8, 16, 0, 0, -1, "t4");
        slot(0, 32'h03, 8, 16, 0, 0, -1, "t4");
        slot(1, 32'h04, 8, 16, 0, 0, -1, "t4");
        chk("t4_ovf_full", ovf, 0);
        chk("t4_valid", valid, 1);
        slot(0, 32'h05, 8, 16, 0, 0, -1, "t4");
        chk("t4_ovf_set", ovf, 1);
        chk("t4_head_stable", {ch, data}, {1'b0, 32'h01000000});
        rdy = 1;
        repeat (6) tick();
        chk("t4_drained", valid, 0);
        pop_chk("t4_w1", {1'b0, 32'h01000000});
        pop_chk("t4_w2", {1'b1, 32'h02000000});
        pop_chk("t4_w3", {1'b0, 32'h03000000});
        pop_chk("t4_w4", {1'b1, 32'h04000000});
        chk("t4_qsize", got.size(), 0);
        chk("t4_ovf_sticky", ovf, 1);
        // Short frame then full word
        chl = 1;
        slot(1, 32'hDEAD, 16, 11, 0, 0, -1, "t5_short");
        slot(0, 32'hBEEF, 16, 32, 0, 0, -1, "t5");
        pop_chk("t5_word", {1'b0, 32'hBEEF0000});
        chk("t5_qsize", got.size(), 0);
        // Disable mid-word with two queued entries
        chl = 0; rdy = 0;
        slot(1, 32'h33, 8, 16, 0, 0, -1, "t6");
        slot(0, 32'h44, 8, 16, 0, 0, -1, "t6");
        slot(1, 32'h55, 8, 6, 0, 0, -1, "t6_part");
        chk("t6_busy_pre", busy, 1);
        chk("t6_valid_pre", valid, 1);
        chk("t6_ovf_pre", ovf, 1);
        chk("t6_head_pre", {ch, data}, {1'b1, 32'h33000000});
        en = 0;
        tick();
        chk("t6_valid_off", valid, 0);
        chk("t6_busy_off", busy, 0);
        chk("t6_ovf_off", ovf, 0);
        chk("t6_out_off", {ch, data}, 33'h0);
        en = 1; rdy = 1;
        for (int i = 0; i < 10; i++) sbit(1, 1, 0, "t6_rest");
        slot(0, 32'h66, 8, 16, 0, 0, -1, "t6_new");
        repeat (4) tick();
        pop_chk("t6_word", {1'b0, 32'h66000000});
        chk("t6_qsize", got.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
